vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 96 +++++++++
 tb/tb_vga_sync_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator. It keeps pixel (x) and line (y) counters that advance
// on pixel-enable cycles. Sync, blanking and end-of-line/frame strobes are
// decoded from those counters, and a modulo-256 frame counter is maintained.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_end,
  output logic       frame_end,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] fc_q, fc_d;
  logic       h_end, v_end;

  assign h_end = (x_q == H_LAST);
  assign v_end = (y_q == V_LAST);

  // Next-state: x steps every ce; y steps when x wraps; frame count steps when both wrap
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fc_d = fc_q;
    if (ce) begin
      if (h_end) begin
        x_d = '0;
        if (v_end) begin
          y_d  = '0;
          fc_d = fc_q + 8'd1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Counter registers; reset wins over counting regardless of ce
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_count = fc_q;

  // Syncs and blanking are pure decodes of the counters, so they hold
  // whenever the counters hold and change in the same cycle as x/y.
  assign hsync      = ((x_q >= HS_START) && (x_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vsync      = ((y_q >= VS_START) && (y_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign display_on = (x_q < H_VIS) && (y_q < V_VIS);

  // End strobes are qualified by ce so each marks exactly one pixel update
  // and reads 0 on stalled cycles.
  assign line_end  = ce & h_end;
  assign frame_end = ce & h_end & v_end;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized check of vga_sync_gen against a linear pixel-index model.
// The bench uses a shrunken timing so that full frames and the 256-frame
// wrap fit in a short run.
module tb_vga_sync_gen;

  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 1;
  localparam bit POL = 1'b0;
  localparam int HT = HD + HF + HS + HB;  // 15
  localparam int VT = VD + VF + VS + VB;  // 10
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset, ce;
  logic [9:0] x, y;
  logic       hsync, vsync, display_on, line_end, frame_end;
  logic [7:0] frame_count;

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .line_end(line_end), .frame_end(frame_end),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int p = 0;       // pixel index within the frame
  int fc = 0;      // completed frames mod 256
  int frames = 0;  // frames completed since the last reset
  int wraps = 0;   // observed 255->0 frame_count rollovers

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (p=%0d fc=%0d)", tag, got, exp, p, fc);
    end
  endtask

  // Compare every output against the model for the current inputs
  task automatic check_all();
    int ex, ey;
    bit  exp_hs, exp_vs;
    ex = p % HT;
    ey = p / HT;
    exp_hs = (ex >= HD + HF && ex < HD + HF + HS) ? POL : !POL;
    exp_vs = (ey >= VD + VF && ey < VD + VF + VS) ? POL : !POL;
    chk("x", int'(x), ex);
    chk("y", int'(y), ey);
    chk("hsync", int'(hsync), int'(exp_hs));
    chk("vsync", int'(vsync), int'(exp_vs));
    chk("display_on", int'(display_on), int'(ex < HD && ey < VD));
    chk("line_end", int'(line_end), int'(ce && ex == HT - 1));
    chk("frame_end", int'(frame_end), int'(ce && p == FRAME - 1));
    chk("frame_count", int'(frame_count), fc);
  endtask

  // One clock: apply inputs, check the pre-edge view, then advance the model
  task automatic step(input logic r, input logic c);
    reset = r;
    ce    = c;
    #1;
    check_all();
    @(posedge clk);
    if (r) begin
      p = 0; fc = 0; frames = 0;
    end else if (c) begin
      if (p == FRAME - 1) begin
        p = 0;
        if (fc == 255) wraps++;
        fc = (fc + 1) % 256;
        frames++;
      end else begin
        p++;
      end
    end
    #1;
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    ce    = 1'b1;
    @(posedge clk);
    #1;
    // Reset held with ce toggling: counters must stay at the origin
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("rst_x", int'(x), 0);
    chk("rst_display_on", int'(display_on), 1);
    chk("rst_hsync", int'(hsync), int'(!POL));

    // First ce after reset moves x 0 -> 1
    step(1'b0, 1'b1);
    chk("first_ce_x", int'(x), 1);

    // Full line with ce=1: x runs through the line, y steps once
    for (int i = 0; i < HT - 1; i++) step(1'b0, 1'b1);
    chk("line_wrap_x", int'(x), 0);
    chk("line_wrap_y", int'(y), 1);

    // Random ce with occasional random resets
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0));

    // Reset in the middle of vertical sync, part-way along the line
    guard = 0;
    while (!((p % HT) == HD + HF + 1 && (p / HT) == VD + VF + 1) && guard < 4 * FRAME) begin
      step(1'b0, 1'b1);
      guard++;
    end
    chk("reach_vsync_point", guard < 4 * FRAME, 1);
    chk("pre_rst_vsync", int'(vsync), int'(POL));
    step(1'b1, $urandom_range(0, 1) != 0);
    chk("post_rst_x", int'(x), 0);
    chk("post_rst_y", int'(y), 0);
    chk("post_rst_vsync", int'(vsync), int'(!POL));

    // ce alternating 1,0 for two frames
    for (int i = 0; i < 4 * FRAME; i++) step(1'b0, (i % 2) == 0);
    chk("alt_frames", frames, 2);

    // Long free run (mostly ce=1) until frame_count has wrapped
    guard = 0;
    while (frames < 260 && guard < 60000) begin
      step(1'b0, $urandom_range(0, 9) != 0);
      guard++;
    end
    chk("free_run_done", guard < 60000, 1);
    chk("fc_wrapped", wraps, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
